// File: rtl/iq_comp_pkg.sv
// Shared types and constants for the adaptive IQ image-rejection compensator.
package iq_comp_pkg;

  localparam logic [1:0] BYPASS = 2'b00;
  localparam logic [1:0] INT_W  = 2'b01;
  localparam logic [1:0] EXT_W  = 2'b10;

  typedef enum logic [2:0] {
    ST_BYP,
    ST_ADAPT,
    ST_SETTLED,
    ST_HOLD,
    ST_EXT
  } state_t;

  // sat_resize(din[IN_W], OUT_W) -> dout[OUT_W]: signed clamp to
  // [-2^(OUT_W-1), 2^(OUT_W-1)-1]; implemented by module iq_comp_sat.

endpackage

// File: rtl/iq_comp_sat.sv
// Signed saturating narrower: clamps a signed IN_W value into OUT_W bits.
module iq_comp_sat #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 4
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] top_bits;

  // Value fits when every bit from the output MSB upward matches the sign.
  always_comb begin
    top_bits = din[IN_W-1:OUT_W-1];
    if ((&top_bits) || !(|top_bits)) begin
      dout = din[OUT_W-1:0];
    end else if (din[IN_W-1]) begin
      dout = MIN_V;
    end else begin
      dout = MAX_V;
    end
  end

endmodule

// File: rtl/iq_comp_adapt.sv
// Adaptive IQ image-rejection compensator: y = x + W*conj(x)/2^MU_SHIFT with
// LMS-style coefficient tracking, a settle detector and external W replay.
module iq_comp_adapt
  import iq_comp_pkg::*;
#(
  parameter int unsigned IQ_W       = 4,
  parameter int unsigned W_W        = 13,
  parameter int unsigned MU_SHIFT   = 11,
  parameter int unsigned SETTLE_THR = 2,
  parameter int unsigned SETTLE_CNT = 16
) (
  input  logic                   clk,
  input  logic                   RESETn,
  input  logic [1:0]             op_mode,
  input  logic                   freeze_iqcomp,
  input  logic                   in_valid,
  input  logic [IQ_W-1:0]        Ix,
  input  logic [IQ_W-1:0]        Qx,
  input  logic signed [W_W-1:0]  Wr_in,
  input  logic signed [W_W-1:0]  Wj_in,
  output logic                   out_valid,
  output logic signed [IQ_W-1:0] Iy,
  output logic signed [IQ_W-1:0] Qy,
  output logic signed [W_W-1:0]  Wr,
  output logic signed [W_W-1:0]  Wj,
  output logic                   settled
);

  localparam int unsigned PROD_W = W_W + IQ_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned COR_W  = SUM_W + 1;
  localparam int unsigned UPD_W  = W_W + 2 * IQ_W + 2;
  localparam int unsigned DW_W   = W_W + 1;
  localparam int unsigned CNT_W  = $clog2(SETTLE_CNT + 1);
  localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(SETTLE_CNT);
  localparam logic signed [DW_W-1:0] THR_P   = DW_W'(SETTLE_THR);
  localparam logic signed [DW_W-1:0] THR_N   = -THR_P;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   settled_d, adapting, quiet;
  logic signed [W_W-1:0]  wr_d, wj_d, wr_use, wj_use, wr_upd, wj_upd;
  logic signed [IQ_W-1:0] iy_d, qy_d, is_s, qs_s, iy_sat, qy_sat;
  logic signed [PROD_W-1:0] p_ri, p_jq, p_ji, p_rq;
  logic signed [SUM_W-1:0]  sum_i, sum_q;
  logic signed [COR_W-1:0]  cor_i, cor_q;
  logic signed [UPD_W-1:0]  upd_r, upd_j;
  logic signed [DW_W-1:0]   dwr, dwj;

  // Offset-binary to two's complement by MSB inversion.
  assign is_s = {~Ix[IQ_W-1], Ix[IQ_W-2:0]};
  assign qs_s = {~Qx[IQ_W-1], Qx[IQ_W-2:0]};

  assign wr_use = (op_mode == INT_W) ? Wr : Wr_in;
  assign wj_use = (op_mode == INT_W) ? Wj : Wj_in;

  assign p_ri  = PROD_W'(wr_use) * PROD_W'(is_s);
  assign p_jq  = PROD_W'(wj_use) * PROD_W'(qs_s);
  assign p_ji  = PROD_W'(wj_use) * PROD_W'(is_s);
  assign p_rq  = PROD_W'(wr_use) * PROD_W'(qs_s);
  assign sum_i = SUM_W'(p_ri) + SUM_W'(p_jq);
  assign sum_q = SUM_W'(p_ji) - SUM_W'(p_rq);
  assign cor_i = COR_W'(is_s) + COR_W'(sum_i >>> MU_SHIFT);
  assign cor_q = COR_W'(qs_s) + COR_W'(sum_q >>> MU_SHIFT);

  // Coefficient step is driven by the currently registered outputs.
  assign upd_r = UPD_W'(Wr) - (UPD_W'(Iy) * UPD_W'(Iy) - UPD_W'(Qy) * UPD_W'(Qy));
  assign upd_j = UPD_W'(Wj) - ((UPD_W'(Iy) * UPD_W'(Qy)) <<< 1);

  iq_comp_sat #(.IN_W(COR_W), .OUT_W(IQ_W)) u_sat_iy (.din(cor_i), .dout(iy_sat));
  iq_comp_sat #(.IN_W(COR_W), .OUT_W(IQ_W)) u_sat_qy (.din(cor_q), .dout(qy_sat));
  iq_comp_sat #(.IN_W(UPD_W), .OUT_W(W_W))  u_sat_wr (.din(upd_r), .dout(wr_upd));
  iq_comp_sat #(.IN_W(UPD_W), .OUT_W(W_W))  u_sat_wj (.din(upd_j), .dout(wj_upd));

  assign dwr   = DW_W'(wr_upd) - DW_W'(Wr);
  assign dwj   = DW_W'(wj_upd) - DW_W'(Wj);
  assign quiet = (dwr <= THR_P) && (dwr >= THR_N) && (dwj <= THR_P) && (dwj >= THR_N);

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state_q   <= ST_BYP;
      cnt_q     <= '0;
      settled   <= 1'b0;
      out_valid <= 1'b0;
      Iy        <= '0;
      Qy        <= '0;
      Wr        <= '0;
      Wj        <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settled   <= settled_d;
      out_valid <= in_valid;
      Iy        <= iy_d;
      Qy        <= qy_d;
      Wr        <= wr_d;
      Wj        <= wj_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = Wr;
    wj_d     = Wj;
    iy_d     = Iy;
    qy_d     = Qy;
    adapting = (state_q == ST_ADAPT) || (state_q == ST_SETTLED);

    if (in_valid) begin
      if ((op_mode == INT_W) || (op_mode == EXT_W)) begin
        iy_d = iy_sat;
        qy_d = qy_sat;
      end else begin
        iy_d = is_s;
        qy_d = qs_s;
      end
    end

    case (op_mode)
      INT_W: begin
        if (freeze_iqcomp) begin
          state_d = ST_HOLD;
        end else begin
          if (in_valid) begin
            wr_d = wr_upd;
            wj_d = wj_upd;
          end
          if (!adapting) begin
            state_d = ST_ADAPT;
            cnt_d   = '0;
          end else if (in_valid) begin
            if (quiet) begin
              if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
              if (cnt_d == CNT_MAX) state_d = ST_SETTLED;
            end else begin
              cnt_d   = '0;
              state_d = ST_ADAPT;
            end
          end
        end
      end
      EXT_W: begin
        state_d = ST_EXT;
        if (in_valid) begin
          wr_d = Wr_in;
          wj_d = Wj_in;
        end
      end
      default: begin
        state_d = ST_BYP;
        if (in_valid) begin
          wr_d = '0;
          wj_d = '0;
        end
      end
    endcase

    settled_d = (state_d == ST_SETTLED) || ((state_d == ST_HOLD) && settled);
  end

endmodule

// File: tb/tb_iq_comp_adapt.sv
// Self-checking bench for iq_comp_adapt: hand-derived vector table, corner
// sequences and a randomized run checked through an expected-value queue.
module tb_iq_comp_adapt;

  logic              clk = 1'b0;
  logic              RESETn;
  logic [1:0]        op_mode;
  logic              freeze_iqcomp;
  logic              in_valid;
  logic [3:0]        Ix, Qx;
  logic signed [12:0] Wr_in, Wj_in;
  logic              out_valid;
  logic signed [3:0] Iy, Qy;
  logic signed [12:0] Wr, Wj;
  logic              settled;

  iq_comp_adapt dut (
    .clk(clk), .RESETn(RESETn), .op_mode(op_mode), .freeze_iqcomp(freeze_iqcomp),
    .in_valid(in_valid), .Ix(Ix), .Qx(Qx), .Wr_in(Wr_in), .Wj_in(Wj_in),
    .out_valid(out_valid), .Iy(Iy), .Qy(Qy), .Wr(Wr), .Wj(Wj), .settled(settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ov; int iy; int qy; int wr; int wj; int st;
  } exp_t;

  typedef struct {
    bit rst; int mode; bit frz; bit vld; int ix; int qx; int wri; int wji;
    int e_iy; int e_qy; int e_wr; int e_st;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model state: m_st 0 BYP, 1 ADAPT, 2 SETTLED, 3 HOLD, 4 EXT.
  int m_st, m_cnt, m_wr, m_wj, m_iy, m_qy, m_set, m_ov;

  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model(input bit rst, input int mode, input bit frz, input bit vld,
                       input int ix, input int qx, input int wri, input int wji);
    int is, qs, uwr, uwj, ci, cq, nwr, nwj, dr, dj;
    bit quiet, adapting;
    exp_t e;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_wr = 0; m_wj = 0; m_iy = 0; m_qy = 0; m_set = 0; m_ov = 0;
    end else begin
      is = ix - 8;
      qs = qx - 8;
      uwr = (mode == 1) ? m_wr : wri;
      uwj = (mode == 1) ? m_wj : wji;
      ci = clamp(is + ((uwr * is + uwj * qs) >>> 11), -8, 7);
      cq = clamp(qs + ((uwj * is - uwr * qs) >>> 11), -8, 7);
      nwr = clamp(m_wr - (m_iy * m_iy - m_qy * m_qy), -4096, 4095);
      nwj = clamp(m_wj - 2 * m_iy * m_qy, -4096, 4095);
      dr = nwr - m_wr;
      dj = nwj - m_wj;
      quiet = (dr >= -2) && (dr <= 2) && (dj >= -2) && (dj <= 2);
      adapting = (m_st == 1) || (m_st == 2);
      m_ov = vld;
      if (vld) begin
        m_iy = (mode == 1 || mode == 2) ? ci : is;
        m_qy = (mode == 1 || mode == 2) ? cq : qs;
      end
      if (mode == 1) begin
        if (frz) m_st = 3;
        else begin
          if (vld) begin m_wr = nwr; m_wj = nwj; end
          if (!adapting) begin m_st = 1; m_cnt = 0; end
          else if (vld) begin
            if (quiet) begin
              m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
              if (m_cnt == 16) m_st = 2;
            end else begin
              m_cnt = 0; m_st = 1;
            end
          end
        end
      end else if (mode == 2) begin
        m_st = 4;
        if (vld) begin m_wr = wri; m_wj = wji; end
      end else begin
        m_st = 0;
        if (vld) begin m_wr = 0; m_wj = 0; end
      end
      m_set = (m_st == 2) ? 1 : (m_st == 3) ? m_set : 0;
    end
    e.ov = m_ov; e.iy = m_iy; e.qy = m_qy; e.wr = m_wr; e.wj = m_wj; e.st = m_set;
    exp_q.push_back(e);
  endtask

  // Drive one cycle, queue the expectation, then compare after the edge.
  task automatic step(input bit rst, input int mode, input bit frz, input bit vld,
                      input int ix, input int qx, input int wri, input int wji);
    exp_t e;
    RESETn        = !rst;
    op_mode       = 2'(mode);
    freeze_iqcomp = frz;
    in_valid      = vld;
    Ix            = 4'(ix);
    Qx            = 4'(qx);
    Wr_in         = 13'(wri);
    Wj_in         = 13'(wji);
    model(rst, mode, frz, vld, ix, qx, wri, wji);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("out_valid", int'(out_valid), e.ov);
      chk("Iy", int'(Iy), e.iy);
      chk("Qy", int'(Qy), e.qy);
      chk("Wr", int'(Wr), e.wr);
      chk("Wj", int'(Wj), e.wj);
      chk("settled", int'(settled), e.st);
    end
  endtask

  task automatic run(input int n, input int mode, input bit frz, input bit vld,
                     input int ix, input int qx);
    for (int i = 0; i < n; i++) step(0, mode, frz, vld, ix, qx, 0, 0);
  endtask

  initial begin
    int rise, fall, wr_frz;
    // rst, mode, frz, vld, ix, qx, wri, wji, Iy, Qy, Wr, settled
    vecs.push_back('{1, 0, 0, 0,  0, 0,     0, 0,  0,  0,     0, 0});
    vecs.push_back('{0, 0, 0, 1, 12, 5,     0, 0,  4, -3,     0, 0});
    vecs.push_back('{0, 2, 0, 1, 12, 8,  2048, 0,  7,  0,  2048, 0});
    vecs.push_back('{0, 2, 0, 1, 14, 8, -1024, 0,  3,  0, -1024, 0});
    vecs.push_back('{1, 0, 0, 0,  0, 0,     0, 0,  0,  0,     0, 0});
    vecs.push_back('{0, 1, 0, 1, 15, 8,     0, 0,  7,  0,     0, 0});
    vecs.push_back('{0, 1, 0, 1, 15, 8,     0, 0,  7,  0,   -49, 0});
    vecs.push_back('{0, 1, 0, 1, 15, 8,     0, 0,  6,  0,   -98, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].mode, vecs[i].frz, vecs[i].vld,
           vecs[i].ix, vecs[i].qx, vecs[i].wri, vecs[i].wji);
      chk($sformatf("vec%0d_Iy", i), int'(Iy), vecs[i].e_iy);
      chk($sformatf("vec%0d_Qy", i), int'(Qy), vecs[i].e_qy);
      chk($sformatf("vec%0d_Wr", i), int'(Wr), vecs[i].e_wr);
      chk($sformatf("vec%0d_settled", i), int'(settled), vecs[i].e_st);
    end

    // Settle: one non-quiet update (old Iy=6) then 16 quiet ones.
    rise = -1;
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0, 1, 8, 8, 0, 0);
      if (settled && rise < 0) rise = i;
    end
    chk("settle_rise_cycle", rise, 17);
    chk("settle_wr", int'(Wr), -134);

    // Burst: first update still sees Iy=0, second sees Iy=6 and breaks settle.
    fall = -1;
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 1, 15, 8, 0, 0);
      if (!settled && fall < 0) fall = i;
    end
    chk("settle_fall_cycle", fall, 2);

    // Freeze: W held while samples keep flowing.
    wr_frz = m_wr;
    for (int i = 0; i < 10; i++) step(0, 1, 1, 1, (i * 5 + 3) % 16, (i * 7 + 1) % 16, 0, 0);
    chk("freeze_wr_held", int'(Wr), wr_frz);

    // Valid gaps: everything held, out_valid low.
    run(5, 1, 0, 0, 3, 12);
    chk("gap_out_valid", int'(out_valid), 0);

    // Reach SETTLED with nonzero W, then reset for one cycle.
    run(24, 1, 0, 1, 8, 8);
    chk("pre_reset_settled", int'(settled), 1);
    chk("pre_reset_wr_nonzero", int'(Wr != 0), 1);
    step(1, 1, 0, 1, 8, 8, 0, 0);
    chk("reset_wr", int'(Wr), 0);
    chk("reset_settled", int'(settled), 0);

    // EXT seed then INT_W: adaptation starts from Wr=500.
    step(0, 2, 0, 1, 8, 8, 500, 0);
    step(0, 1, 0, 1, 15, 8, 0, 0);
    chk("seed_wr_first", int'(Wr), 500);
    chk("seed_iy_first", int'(Iy), 7);
    step(0, 1, 0, 1, 15, 8, 0, 0);
    chk("seed_wr_second", int'(Wr), 451);

    // Randomized mix of all modes, freeze and valid gaps.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      step(r == 0 && i > 0 && ($urandom_range(0, 9) == 0),
           (r < 6) ? 1 : (r < 8) ? 2 : int'($urandom_range(0, 1)) * 3,
           $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 15), $urandom_range(0, 15),
           int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
